// File: rtl/bsg_rf_operand_fetch_if.sv
// bsg_rf_operand_fetch_if: request, register-file port and result signals of the operand-fetch stage.
// master is the fetch stage's view, slave is the surrounding pipeline/RAM view.
interface bsg_rf_operand_fetch_if #(
    parameter int width_p     = 32,
    parameter int els_p       = 32,
    parameter int tag_width_p = 4
);
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    logic                     v_i;
    logic                     ready_o;
    logic [addr_width_lp-1:0] rs0_addr_i;
    logic [addr_width_lp-1:0] rs1_addr_i;
    logic [tag_width_p-1:0]   tag_i;
    logic                     w_v_i;
    logic [addr_width_lp-1:0] w_addr_i;
    logic [width_p-1:0]       w_data_i;
    logic                     rf_r0_v_o;
    logic                     rf_r1_v_o;
    logic [addr_width_lp-1:0] rf_r0_addr_o;
    logic [addr_width_lp-1:0] rf_r1_addr_o;
    logic [width_p-1:0]       rf_r0_data_i;
    logic [width_p-1:0]       rf_r1_data_i;
    logic                     rf_w_v_o;
    logic [addr_width_lp-1:0] rf_w_addr_o;
    logic [width_p-1:0]       rf_w_data_o;
    logic                     v_o;
    logic                     ready_i;
    logic [width_p-1:0]       data0_o;
    logic [width_p-1:0]       data1_o;
    logic [tag_width_p-1:0]   tag_o;
    modport master (
        input  v_i, rs0_addr_i, rs1_addr_i, tag_i, w_v_i, w_addr_i, w_data_i,
               rf_r0_data_i, rf_r1_data_i, ready_i,
        output ready_o, rf_r0_v_o, rf_r1_v_o, rf_r0_addr_o, rf_r1_addr_o,
               rf_w_v_o, rf_w_addr_o, rf_w_data_o, v_o, data0_o, data1_o, tag_o
    );
    modport slave (
        output v_i, rs0_addr_i, rs1_addr_i, tag_i, w_v_i, w_addr_i, w_data_i,
               rf_r0_data_i, rf_r1_data_i, ready_i,
        input  ready_o, rf_r0_v_o, rf_r1_v_o, rf_r0_addr_o, rf_r1_addr_o,
               rf_w_v_o, rf_w_addr_o, rf_w_data_o, v_o, data0_o, data1_o, tag_o
    );
endinterface

// File: rtl/bsg_rf_operand_fetch.sv
// bsg_rf_operand_fetch: two-operand fetch in front of a 2r1w sync RAM, forwarding writes so the
// RAM never sees a same-address read/write and a stalled result stays coherent with later writes.
module bsg_rf_operand_fetch #(
    parameter int width_p     = 32,
    parameter int els_p       = 32,
    parameter int tag_width_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_rf_operand_fetch_if.master       bus
);
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    logic                     full_q, held_q;
    logic [1:0]               byp_q;
    logic [tag_width_p-1:0]   tag_q;
    logic [addr_width_lp-1:0] rs_q [2];
    logic [width_p-1:0]       hold_q [2];
    logic [addr_width_lp-1:0] rs_in [2];
    logic [width_p-1:0]       rd [2];
    logic [width_p-1:0]       dout [2];
    logic                     col [2];
    logic                     match [2];
    logic                     accept, consume;
    assign rs_in[0] = bus.rs0_addr_i;
    assign rs_in[1] = bus.rs1_addr_i;
    assign rd[0]    = bus.rf_r0_data_i;
    assign rd[1]    = bus.rf_r1_data_i;
    assign bus.ready_o = reset_n_i & (~full_q | bus.ready_i);
    assign accept      = bus.v_i & bus.ready_o;
    assign consume     = full_q & bus.ready_i;
    for (genvar p = 0; p < 2; p++) begin : g_port
        assign col[p]   = bus.w_v_i & (bus.w_addr_i == rs_in[p]);
        assign match[p] = bus.w_v_i & (bus.w_addr_i == rs_q[p]);
        // RAM data is only valid in the first cycle after the accept; afterwards hold_q tracks it
        assign dout[p]  = ~full_q ? '0 : (~held_q & ~byp_q[p]) ? rd[p] : hold_q[p];
    end
    assign bus.rf_r0_v_o    = accept & ~col[0];
    assign bus.rf_r1_v_o    = accept & ~col[1];
    assign bus.rf_r0_addr_o = bus.rs0_addr_i;
    assign bus.rf_r1_addr_o = bus.rs1_addr_i;
    assign bus.rf_w_v_o     = reset_n_i & bus.w_v_i;
    assign bus.rf_w_addr_o  = bus.w_addr_i;
    assign bus.rf_w_data_o  = bus.w_data_i;
    assign bus.v_o          = full_q;
    assign bus.data0_o      = dout[0];
    assign bus.data1_o      = dout[1];
    assign bus.tag_o        = tag_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q <= 1'b0;
            held_q <= 1'b0;
            byp_q  <= '0;
            tag_q  <= '0;
            for (int p = 0; p < 2; p++) begin
                rs_q[p]   <= '0;
                hold_q[p] <= '0;
            end
        end else if (accept) begin
            full_q <= 1'b1;
            held_q <= 1'b0;
            tag_q  <= bus.tag_i;
            for (int p = 0; p < 2; p++) begin
                rs_q[p]  <= rs_in[p];
                byp_q[p] <= col[p];
                if (col[p]) hold_q[p] <= bus.w_data_i;
            end
        end else if (consume) begin
            full_q <= 1'b0;
            held_q <= 1'b0;
        end else if (full_q) begin
            held_q <= 1'b1;
            for (int p = 0; p < 2; p++)
                hold_q[p] <= match[p] ? bus.w_data_i : dout[p];
        end
    end
endmodule

// File: doc/bsg_rf_operand_fetch.md
# bsg_rf_operand_fetch

Operand-fetch stage in front of the `bsg_mem_2r1w_sync` register file. It takes two-source read requests, issues them to the RAM's two synchronous read ports, and owns the RAM's write port. It forwards write data wherever a read and a write meet, so the RAM never sees a same-address read/write, which the hardened macro forbids. It returns both operands plus a tag through a valid/ready handshake, and keeps a stalled result current against later writes.

## Interface
- `width_p`, 32, operand/data width
- `els_p`, 32, register count
- `tag_width_p`, 4, opaque request tag width
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`, address width (derived)

Ports:
- `clk_i` in 1: single clock; all state on rising edge
- `reset_n_i` in 1: reset, asynchronous, active-low
- `v_i` in 1: request valid
- `ready_o` out 1: request accepted when `v_i & ready_o`
- `rs0_addr_i`, `rs1_addr_i` in `addr_width_lp`: source addresses
- `tag_i` in `tag_width_p`: request tag, returned unchanged
- `w_v_i` in 1: write valid; writes are never back-pressured
- `w_addr_i` in `addr_width_lp`: write address
- `w_data_i` in `width_p`: write data
- `rf_r0_v_o`, `rf_r1_v_o` out 1: RAM read enables
- `rf_r0_addr_o`, `rf_r1_addr_o` out `addr_width_lp`: RAM read addresses
- `rf_r0_data_i`, `rf_r1_data_i` in `width_p`: RAM read data, valid one cycle after the read enable
- `rf_w_v_o` out 1: RAM write enable
- `rf_w_addr_o` out `addr_width_lp`: RAM write address
- `rf_w_data_o` out `width_p`: RAM write data
- `v_o` out 1: result valid
- `ready_i` in 1: result consumed when `v_o & ready_i`
- `data0_o`, `data1_o` out `width_p`: operands
- `tag_o` out `tag_width_p`: tag of the presented result

## Operation
- Two states per result slot: EMPTY and FULL. Within FULL, a `held` flag selects FRESH (`held`=0) or HELD (`held`=1).
- `ready_o = reset_n_i & (~FULL | ready_i)`. A new request may be accepted in the same cycle the current result is consumed.
- Accept in cycle T:
  - Capture addresses and tag into the slot.
  - Per port p, collision `c_p = w_v_i & (w_addr_i == rs_p)`.
  - `rf_rp_v_o = accept & ~c_p`; `rf_rp_addr_o = rs_p` always.
  - If `c_p`: set bypass flag `byp_p` and capture `w_data_i` into `hold_p`. The RAM read is suppressed.
- Write port is pass-through: `rf_w_*_o = w_*_i`, with `rf_w_v_o` gated low while `reset_n_i` is low.
- Data select per port:
  - FRESH and `~byp_p`: `rf_rp_data_i`.
  - Otherwise: `hold_p`.
- FULL at the end of a cycle and not consumed:
  - Each `hold_p` loads the currently presented value.
  - A write in that cycle whose address matches `rs_p` overrides it with `w_data_i`.
  - Set `held`=1.
- FULL and HELD, not consumed, matching write: update `hold_p` with `w_data_i`.
- Write matching both `rs0` and `rs1`: both ports update.
- `rs0 == rs1` is legal; both operands are identical.
- Coherence rule: `data_p_o` in cycle C equals the register contents after all writes with `w_v_i` in cycles ≤ C-1.
- Consume without a new accept: go to EMPTY.
- Consume with a new accept: stay FULL with the new slot, FRESH.
- Reset (async, any time): slot EMPTY, pending result discarded, flags 0, `v_o`=0, `data*_o`=0, `tag_o`=0, all `rf_*_v_o`=0.

## Timing
- Read latency: accept at T gives `v_o`=1 at T+1. Full throughput is 1 result/cycle while `ready_i`=1.
- `rf_rp_v_o` is combinational from `v_i`, `ready_i`, `w_*_i`. `rf_w_*_o` is combinational from `w_*_i`.
- `data*_o` never depends combinationally on `w_data_i` or `ready_i`.
- While `v_o`=1 and `ready_i`=0, `tag_o` is stable. `data*_o` changes only per the coherence rule.
- The block never asserts `rf_rp_v_o` and `rf_w_v_o` to the same address in one cycle; the bench asserts this.

## Test plan
- Reset, then write r3=0xA5A5_0003 at cycle 0; request rs0=3, rs1=4, tag=2 at cycle 2 with `ready_i`=1 -> `v_o` at 3, data0=0xA5A5_0003, data1=prior r4, tag=2.
- Same-cycle write r5=0x55 and request rs0=rs1=5 -> `rf_r0_v_o`=`rf_r1_v_o`=0 that cycle; next cycle data0=data1=0x55, no RAM collision.
- Back-to-back requests for 8 cycles with `ready_i`=1 -> 8 consecutive results, `ready_o` stays 1, tags in order.
- Result presented with `ready_i`=0 for 3 cycles; write r7=0x77 in stall cycle 1, r7=0x78 in stall cycle 2, rs1=7 -> data1 is 0x77 in stall cycle 2 and 0x78 in stall cycle 3; `ready_o`=0 throughout stall.
- Consume and accept in the same cycle -> no bubble; the new result appears the next cycle.
- Assert `reset_n_i` low mid-stall -> `v_o`, `ready_o`, `rf_*_v_o` go 0 immediately; after release the first request returns correct data with no stale output.
